uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmit path. It is the counterpart to the receive-side FIFO and uses the same flag semantics and the same BIST freeze. Host-side writes are buffered in a 2**FIFO_WIDTH-entry FIFO, and a frame engine serializes each entry as start / data (LSB first) / optional parity / stop on Tx, with a bit timer driven by CLKS_PER_BIT. It sits between the host register interface and the UART pin.

Parameters:
DATA_BITS, 8, data bits per frame and FIFO entry width
FIFO_WIDTH, 4, log2 of FIFO depth (16 entries)
CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
Tx_Data  in  DATA_BITS  byte to transmit
Load_Data  in  1  push Tx_Data into FIFO (one entry per cycle high)
BIST_Mode  in  1  freeze: ignore pushes, start no new frame
Tx  out  1  serial line, idle high
Tx_Busy  out  1  high while a frame is on the line (state != IDLE)
Tx_Done  out  1  one-cycle pulse as each stop bit completes
FIFO_Empty  out  1  entry count == 0
FIFO_Full  out  1  entry count == 2**FIFO_WIDTH
FIFO_Overflow  out  1  one-cycle pulse when a push is dropped

Behaviour:
- Reset (rst_n low, asynchronous):
  - Tx=1, Tx_Busy=0, Tx_Done=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0.
  - Pointers and count are 0 and the state is IDLE.
  - A frame in progress is aborted immediately. FIFO contents are discarded.
- All outputs are registered. Tx is driven directly from a flop.
- FIFO:
  - Circular buffer with FIFO_WIDTH-bit read and write pointers that wrap naturally.
  - The count is FIFO_WIDTH+1 bits.
- Push: Load_Data=1 and BIST_Mode=0 writes Tx_Data at the write pointer if count < depth, or if a pop occurs in the same cycle.
- Overflow: a push while full with no pop in that cycle drops the data, and FIFO_Overflow pulses high for 1 cycle. Count is unchanged.
- Push with BIST_Mode=1 is ignored silently, with no overflow pulse.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- No bypass: a byte written into an empty FIFO is popped no earlier than the next edge.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1. When the FIFO is non-empty and BIST_Mode=0:
    - pop the head into the shift register;
    - compute parity (even: XOR of data bits; odd: inverted);
    - clear the bit timer and bit index;
    - go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: Tx=shift[0] for each bit, shifting right after every CLKS_PER_BIT cycles. After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY: Tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles. On the final cycle, Tx_Done pulses.
    - If the FIFO is non-empty and BIST_Mode=0, pop and go straight to START, with no idle gap between frames.
    - Otherwise go to IDLE.
- Latency:
  - Load_Data sampled at edge N into an empty FIFO while IDLE gives FIFO_Empty=0 after N.
  - Tx falls after edge N+1.
- Frame length is exactly (2 + DATA_BITS + (PARITY != 0)) * CLKS_PER_BIT cycles.
- Bit timer counts 0..CLKS_PER_BIT-1 and needs ceil(log2(CLKS_PER_BIT)) bits.
- BIST_Mode asserted mid-frame: the current frame completes normally, and no further pop occurs until BIST_Mode=0.
- FIFO_Empty and FIFO_Full reflect the count after each edge.

Test Plan:
- Single frame: CLKS_PER_BIT=4, PARITY=0. Push 0xA5 once.
  - Tx levels, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - Tx_Busy high for 40 cycles, then Tx_Done pulses once and Tx stays 1.
- Parity: PARITY=1, push 0x07 → parity bit 1 with a 44-cycle frame. PARITY=2, push 0x07 → parity bit 0.
- Fill and overflow:
  - With BIST_Mode=1, push 16 bytes → none accepted, FIFO_Empty stays 1.
  - With BIST_Mode=0 and the engine held busy by a frame already in progress, push 17 bytes 0x00..0x10.
  - FIFO_Full=1 after the 16th push is accepted. The 17th push pulses FIFO_Overflow for 1 cycle.
  - Transmitted sequence is the in-progress byte followed by 0x00..0x0F in order, with the 0x10 push dropped.
- Back-to-back and wrap: push 20 bytes spread over time so the pointers wrap.
  - Frames are contiguous, with no idle cycle between stop and start.
  - Bytes arrive in order.
  - Push while full coinciding with a pop is accepted.
- BIST mid-frame: assert BIST_Mode during DATA of byte 0x3C with 0x55 queued.
  - 0x3C completes and Tx_Done pulses.
  - 0x55 is held and starts 2 cycles after BIST_Mode deasserts.
- Reset mid-frame: pull rst_n low during DATA.
  - Tx=1, Tx_Busy=0, FIFO_Empty=1 immediately, without waiting for a clock edge.
  - After release, no frame starts until a new push.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit path: host writes land in a circular FIFO and a frame engine
// serializes each entry as start / data LSB-first / optional parity / stop.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Load_Data,
    input  logic                 BIST_Mode,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow
);
    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam int TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0]       T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]       B_LAST   = BW'(DATA_BITS - 1);
    localparam logic [FIFO_WIDTH:0] FULL_CNT = (FIFO_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [BW-1:0]         bit_idx_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  parity_q;
    logic                  tx_q, busy_q, done_q, empty_q, full_q, ovf_q;
    logic [FIFO_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_WIDTH:0]   count_q, count_d;
    logic [DATA_BITS-1:0]  mem_q [DEPTH];

    logic                  bit_end, pop, push, accept, par_bit;
    logic [DATA_BITS-1:0]  head, shift_nxt;

    assign bit_end   = (timer_q == T_LAST);
    assign head      = mem_q[rd_ptr_q];
    assign shift_nxt = shift_q >> 1;
    assign par_bit   = (PARITY == 2) ? ~^head : ^head;

    // A pop may only happen from IDLE or on the last cycle of a stop bit,
    // which is what makes back-to-back frames gapless.
    assign pop    = ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end))
                    && (count_q != '0) && !BIST_Mode;
    assign push   = Load_Data && !BIST_Mode;
    assign accept = push && ((count_q != FULL_CNT) || pop);

    always_comb begin
        count_d = count_q;
        if (accept && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !accept)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem_q[wr_ptr_q] <= Tx_Data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            ovf_q   <= push && !accept;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
            if (accept)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;

            if (pop) begin
                shift_q   <= head;
                parity_q  <= par_bit;
                timer_q   <= '0;
                bit_idx_q <= '0;
                state_q   <= S_START;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                if (state_q == S_STOP)
                    done_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            timer_q <= '0;
                            state_q <= S_DATA;
                            tx_q    <= shift_q[0];
                        end else
                            timer_q <= timer_q + 1'b1;
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            timer_q <= '0;
                            if (bit_idx_q == B_LAST) begin
                                if (PARITY != 0) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= parity_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                shift_q   <= shift_nxt;
                                tx_q      <= shift_nxt[0];
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end else
                            timer_q <= timer_q + 1'b1;
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            timer_q <= '0;
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else
                            timer_q <= timer_q + 1'b1;
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            timer_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else
                            timer_q <= timer_q + 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign Tx            = tx_q;
    assign Tx_Busy       = busy_q;
    assign Tx_Done       = done_q;
    assign FIFO_Empty    = empty_q;
    assign FIFO_Full     = full_q;
    assign FIFO_Overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line monitor decodes frames on the main
// instance and checks them against a queue of expected bytes.
module tb_uart_tx;
    localparam int CPB = 4;

    logic       clk, rst_n, bist;
    logic [7:0] txData;
    logic       load0, load1, load2;
    logic       tx0, busy0, done0, empty0, full0, ovf0;
    logic       tx1, busy1, done1, empty1, full1, ovf1;
    logic       tx2, busy2, done2, empty2, full2, ovf2;

    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    logic [7:0] sb[$];
    int         frameStarts[$];

    uart_tx #(.DATA_BITS(8), .FIFO_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Tx_Data(txData), .Load_Data(load0), .BIST_Mode(bist),
        .Tx(tx0), .Tx_Busy(busy0), .Tx_Done(done0), .FIFO_Empty(empty0),
        .FIFO_Full(full0), .FIFO_Overflow(ovf0));

    uart_tx #(.DATA_BITS(8), .FIFO_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Tx_Data(txData), .Load_Data(load1), .BIST_Mode(bist),
        .Tx(tx1), .Tx_Busy(busy1), .Tx_Done(done1), .FIFO_Empty(empty1),
        .FIFO_Full(full1), .FIFO_Overflow(ovf1));

    uart_tx #(.DATA_BITS(8), .FIFO_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Tx_Data(txData), .Load_Data(load2), .BIST_Mode(bist),
        .Tx(tx2), .Tx_Busy(busy2), .Tx_Done(done2), .FIFO_Empty(empty2),
        .FIFO_Full(full2), .FIFO_Overflow(ovf2));

    // Free-running clock and a cycle counter used to time pushes and frame starts
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLoad(int s, logic v);
        case (s)
            1:       load1 = v;
            2:       load2 = v;
            default: load0 = v;
        endcase
    endtask

    task automatic applyStimulus(int s, logic [7:0] d);
        txData = d;
        setLoad(s, 1'b1);
        tick();
        setLoad(s, 1'b0);
    endtask

    function automatic logic txSel(int s);
        case (s)
            1:       return tx1;
            2:       return tx2;
            default: return tx0;
        endcase
    endfunction

    function automatic logic busySel(int s);
        case (s)
            1:       return busy1;
            2:       return busy2;
            default: return busy0;
        endcase
    endfunction

    function automatic logic doneSel(int s);
        case (s)
            1:       return done1;
            2:       return done2;
            default: return done0;
        endcase
    endfunction

    task automatic waitDrain(int bound);
        int n = 0;
        while ((sb.size() != 0 || busy0 !== 1'b0) && n < bound) begin
            tick();
            n++;
        end
        checkOutput("drainTimeout", 32'(n < bound), 1);
    endtask

    // Captures one 44-cycle parity frame on a parity instance and checks it
    task automatic runParity(int s, logic expPar);
        logic [43:0] ln;
        logic [7:0]  dataBits;
        int          busyCnt = 0;
        applyStimulus(s, 8'h07);
        tick();
        for (int i = 0; i < 44; i++) begin
            ln[i] = txSel(s);
            if (busySel(s)) busyCnt++;
            tick();
        end
        for (int k = 0; k < 8; k++) dataBits[k] = ln[4 + 4 * k];
        checkOutput($sformatf("par%0dStart", s), 32'(ln[0]), 0);
        checkOutput($sformatf("par%0dData", s), 32'(dataBits), 32'h07);
        checkOutput($sformatf("par%0dBit", s), 32'(ln[36]), 32'(expPar));
        checkOutput($sformatf("par%0dStop", s), 32'(ln[40]), 1);
        checkOutput($sformatf("par%0dLen", s), busyCnt, 44);
        checkOutput($sformatf("par%0dDone", s), 32'(doneSel(s)), 1);
    endtask

    // Line monitor: decodes every frame on dut0 and pops the scoreboard
    logic [9:0] monLv;
    logic       monBad, monAbort;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx0 === 1'b0) begin
                frameStarts.push_back(cyc);
                monBad   = 1'b0;
                monAbort = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (rst_n !== 1'b1) monAbort = 1'b1;
                        if (k == 0) monLv[b] = tx0;
                        else if (tx0 !== monLv[b]) monBad = 1'b1;
                    end
                end
                if (!monAbort) begin
                    checkOutput("frameShape", {29'b0, monBad, monLv[0], monLv[9]}, 32'b001);
                    checkOutput("frameExpected", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0)
                        checkOutput("frameByte", 32'(monLv[8:1]), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        int busyCnt, t0, startIdx, nStarts, badGaps, n;
        logic sawOvf, found;

        rst_n = 1'b0; bist = 1'b0; txData = '0;
        load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
        repeat (3) tick();
        checkOutput("rstTx", 32'(tx0), 1);
        checkOutput("rstBusy", 32'(busy0), 0);
        checkOutput("rstDone", 32'(done0), 0);
        checkOutput("rstEmpty", 32'(empty0), 1);
        checkOutput("rstFull", 32'(full0), 0);
        checkOutput("rstOvf", 32'(ovf0), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single frame 0xA5");
        applyStimulus(0, 8'hA5);
        sb.push_back(8'hA5);
        checkOutput("pushEmpty", 32'(empty0), 0);
        checkOutput("txIdleAfterPush", 32'(tx0), 1);
        tick();
        checkOutput("startLow", 32'(tx0), 0);
        busyCnt = 0;
        while (busy0 && busyCnt < 100) begin
            tick();
            busyCnt++;
        end
        checkOutput("busyLen", busyCnt, 40);
        checkOutput("donePulse", 32'(done0), 1);
        checkOutput("txAfterFrame", 32'(tx0), 1);
        tick();
        checkOutput("doneOnce", 32'(done0), 0);
        checkOutput("emptyAfterFrame", 32'(empty0), 1);

        $display("[TB] parity frames");
        runParity(1, 1'b1);
        runParity(2, 1'b0);

        $display("[TB] pushes under BIST");
        bist = 1'b1;
        sawOvf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'(i));
            if (ovf0) sawOvf = 1'b1;
        end
        bist = 1'b0;
        checkOutput("bistEmpty", 32'(empty0), 1);
        checkOutput("bistNoOvf", 32'(sawOvf), 0);
        tick();
        checkOutput("bistNoFrame", 32'(busy0), 0);

        $display("[TB] fill and overflow");
        applyStimulus(0, 8'hEE);
        sb.push_back(8'hEE);
        tick();
        checkOutput("fillBusy", 32'(busy0), 1);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(0, 8'(k));
            if (k < 16) sb.push_back(8'(k));
            if (k == 14) checkOutput("notFull15", 32'(full0), 0);
            if (k == 15) checkOutput("full16", 32'(full0), 1);
            if (k == 16) begin
                checkOutput("ovfPulse", 32'(ovf0), 1);
                checkOutput("fullAfterOvf", 32'(full0), 1);
            end
        end
        tick();
        checkOutput("ovfOneCycle", 32'(ovf0), 0);
        waitDrain(17 * 40 + 200);

        $display("[TB] back-to-back with pointer wrap");
        startIdx = frameStarts.size();
        applyStimulus(0, 8'h40);
        t0 = cyc;
        sb.push_back(8'h40);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(0, 8'(8'h40 + i));
            sb.push_back(8'(8'h40 + i));
        end
        checkOutput("b2bNotFull", 32'(full0), 0);
        applyStimulus(0, 8'h50);
        sb.push_back(8'h50);
        checkOutput("b2bFull", 32'(full0), 1);
        while (cyc < t0 + 40) tick();
        applyStimulus(0, 8'h51);
        sb.push_back(8'h51);
        checkOutput("fullPushPopNoOvf", 32'(ovf0), 0);
        checkOutput("fullPushPopFull", 32'(full0), 1);
        while (cyc < t0 + 100) tick();
        applyStimulus(0, 8'h52);
        sb.push_back(8'h52);
        while (cyc < t0 + 150) tick();
        applyStimulus(0, 8'h53);
        sb.push_back(8'h53);
        waitDrain(20 * 40 + 200);
        badGaps = 0;
        for (int i = startIdx + 1; i < frameStarts.size(); i++)
            if (frameStarts[i] - frameStarts[i-1] != 40) badGaps++;
        checkOutput("b2bFrames", frameStarts.size() - startIdx, 20);
        checkOutput("b2bGaps", badGaps, 0);

        $display("[TB] BIST mid-frame");
        applyStimulus(0, 8'h3C);
        sb.push_back(8'h3C);
        applyStimulus(0, 8'h55);
        sb.push_back(8'h55);
        repeat (10) tick();
        bist = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            tick();
            n++;
            if (done0) found = 1'b1;
        end
        checkOutput("bistFrameDone", 32'(found), 1);
        checkOutput("bistIdleAfter", 32'(busy0), 0);
        repeat (10) tick();
        checkOutput("bistHeldTx", 32'(tx0), 1);
        checkOutput("bistHeldBusy", 32'(busy0), 0);
        checkOutput("bistHeldQueued", 32'(empty0), 0);
        bist = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (tx0 === 1'b0) found = 1'b1;
        end
        checkOutput("bistReleaseStart", 32'(found), 1);
        waitDrain(200);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h99);
        sb.push_back(8'h99);
        repeat (12) tick();
        nStarts = frameStarts.size();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstTx", 32'(tx0), 1);
        checkOutput("asyncRstBusy", 32'(busy0), 0);
        checkOutput("asyncRstEmpty", 32'(empty0), 1);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (60) tick();
        checkOutput("noFrameAfterRst", frameStarts.size() - nStarts, 0);
        checkOutput("idleAfterRstTx", 32'(tx0), 1);
        checkOutput("idleAfterRstBusy", 32'(busy0), 0);
        applyStimulus(0, 8'h5A);
        sb.push_back(8'h5A);
        waitDrain(200);
        checkOutput("finalEmpty", 32'(empty0), 1);
        checkOutput("sbDrained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
